dca_matrix_row_drainer: RTL and testbench
=========================================

Name: dca_matrix_row_drainer

Overview:
Sequencer that empties a DCA matrix register one row per handshake. It sits directly downstream of the matrix register, reads the register's upmost-row output and drives the register's shift_up and transpose controls. Each row is presented on a valid/ready stream to the next consumer, such as the output DMA or the accumulator write-back. An optional transpose is applied before draining, so the matrix can be emitted column-major.

Parameters:
MATRIX_SIZE_PARA, 8, rows/columns of the square matrix (N)
BW_TENSOR_SCALAR, 32, bits per matrix element
BW_TENSOR_ROW, MATRIX_SIZE_PARA*BW_TENSOR_SCALAR (derived, localparam), bits per row
BW_ROW_INDEX, max(1, clog2(MATRIX_SIZE_PARA)) (derived, localparam), row counter width

Ports:
clk  input  1  clock, rising edge
rstnn  input  1  asynchronous active-low reset
start  input  1  one-cycle request to drain the whole matrix; honoured only in IDLE
transpose_first  input  1  sampled with start; 1 = transpose the register before draining
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse after the last row handshake
mreg_transpose  output  1  to the matrix register transpose input
mreg_shift_up  output  1  to the matrix register shift_up input
mreg_upmost_rdata_list1d  input  BW_TENSOR_ROW  from the matrix register upmost_rdata_list1d
row_valid  output  1  row available on row_data
row_ready  input  1  consumer accepts the row
row_data  output  BW_TENSOR_ROW  current top row
row_index  output  BW_ROW_INDEX  0-based index of the row being offered
row_last  output  1  high together with row_valid when row_index == N-1

Behaviour:
- Clocking and reset: one clock, clk. rstnn is asynchronous and active-low.
- Reset values: state=IDLE, counter=0, busy=0, done=0, row_valid=0, row_last=0, row_index=0, mreg_transpose=0, mreg_shift_up=0. row_data is a pass-through of mreg_upmost_rdata_list1d.
- FSM states: IDLE, XPOSE, STREAM, FINISH.
- IDLE:
  - start=1 and transpose_first=1 -> XPOSE.
  - start=1 and transpose_first=0 -> STREAM.
  - Counter is cleared on the start cycle.
- XPOSE: lasts exactly one cycle. mreg_transpose=1 (combinational from state). Next state is STREAM. The register updates on this edge, so STREAM sees transposed data.
- STREAM:
  - row_valid=1, row_data=mreg_upmost_rdata_list1d, row_index=counter, row_last=(counter==N-1).
  - mreg_shift_up = row_valid & row_ready, combinational and in the same cycle as the handshake.
  - On handshake with counter<N-1: counter++.
  - On handshake with counter==N-1: next state FINISH, counter=0.
  - With row_ready=0: no shift, row_data and row_index stay stable, and row_valid stays high (AXI-style; valid is never withdrawn).
- FINISH: done=1 for one cycle, then IDLE. busy=1 in FINISH.
- Latency:
  - Without transpose: start -> first row_valid is 1 cycle.
  - With transpose: start -> first row_valid is 2 cycles.
  - Full drain with row_ready tied high: N cycles of STREAM.
- Boundary conditions:
  - start while busy is ignored; no queuing.
  - start in the same cycle as done is ignored, because the state is FINISH, not IDLE.
  - mreg_transpose and mreg_shift_up are never high in the same cycle.
  - rstnn low mid-drain returns everything to reset values immediately. The matrix register holds a partially shifted matrix; recovering it is the controller's job.
  - MATRIX_SIZE_PARA=1: BW_ROW_INDEX=1, one row, and row_last=1 on the first and only row.
- Arithmetic: counter wraps only through the explicit clear, never by overflow.
- No combinational path from row_ready to row_valid. row_ready reaches only mreg_shift_up and the next state.

Decomposition:
- Shared package/include: the FSM state encodings (DCA_DRAIN_IDLE/XPOSE/STREAM/FINISH) and the BW_TENSOR_ROW/BW_ROW_INDEX derivation go in the existing matrix dimension include set, so that a future row loader reuses them.
- No sub-module: a single FSM plus counter, about 150 lines.

Test Plan:
- N=4, scalar=8, register preloaded with rows 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; start, transpose_first=0, row_ready=1 -> rows emitted in that order on cycles 1-4, row_index 0..3, row_last only on 0x0F0E0D0C, done on cycle 5, exactly 4 shift_up pulses.
- Same preload, transpose_first=1 -> mreg_transpose high for exactly 1 cycle; rows emitted 0x0C080400, 0x0D090501, 0x0E0A0602, 0x0F0B0703.
- Random row_ready backpressure (e.g. 1,0,0,1,0,1,1) -> row_data/row_index held while stalled, shift_up only on handshake cycles, 4 rows emitted, no duplicates or drops.
- start pulsed while in STREAM and again on the done cycle -> both ignored; a single drain of 4 rows; busy falls the cycle after done.
- rstnn asserted after the second handshake -> all outputs return to reset values asynchronously; a new start drains from counter 0.
- N=1 build -> a single row with row_last=1, done on the following cycle.

Source files
------------

// File: rtl/dca_matrix_row_drainer_pkg.sv
// Shared matrix-dimension definitions for DCA matrix sequencers (drainer now, loader later).
package dca_matrix_row_drainer_pkg;

  typedef enum logic [1:0] {
    DCA_DRAIN_IDLE   = 2'd0,
    DCA_DRAIN_XPOSE  = 2'd1,
    DCA_DRAIN_STREAM = 2'd2,
    DCA_DRAIN_FINISH = 2'd3
  } dca_drain_state_e;

  function automatic int unsigned dca_row_bw(input int unsigned n, input int unsigned w);
    return n * w;
  endfunction

  // A single-row matrix still needs a 1-bit index.
  function automatic int unsigned dca_row_index_bw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dca_matrix_row_drainer.sv
// Empties a DCA matrix register one row per valid/ready handshake, optionally
// transposing it first so the matrix leaves column-major.
module dca_matrix_row_drainer
  import dca_matrix_row_drainer_pkg::*;
#(
  parameter int unsigned MATRIX_SIZE_PARA = 8,
  parameter int unsigned BW_TENSOR_SCALAR = 32,
  localparam int unsigned BW_TENSOR_ROW = dca_row_bw(MATRIX_SIZE_PARA, BW_TENSOR_SCALAR),
  localparam int unsigned BW_ROW_INDEX  = dca_row_index_bw(MATRIX_SIZE_PARA)
) (
  input  logic                     clk,
  input  logic                     rstnn,
  input  logic                     start,
  input  logic                     transpose_first,
  output logic                     busy,
  output logic                     done,
  output logic                     mreg_transpose,
  output logic                     mreg_shift_up,
  input  logic [BW_TENSOR_ROW-1:0] mreg_upmost_rdata_list1d,
  output logic                     row_valid,
  input  logic                     row_ready,
  output logic [BW_TENSOR_ROW-1:0] row_data,
  output logic [BW_ROW_INDEX-1:0]  row_index,
  output logic                     row_last
);

  localparam logic [BW_ROW_INDEX-1:0] LastIdx = BW_ROW_INDEX'(MATRIX_SIZE_PARA - 1);

  dca_drain_state_e          state_q, state_d;
  logic [BW_ROW_INDEX-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q <= DCA_DRAIN_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      DCA_DRAIN_IDLE: begin
        if (start) begin
          cnt_d   = '0;
          state_d = transpose_first ? DCA_DRAIN_XPOSE : DCA_DRAIN_STREAM;
        end
      end
      // The register transposes on this edge, so STREAM already sees the new layout.
      DCA_DRAIN_XPOSE: state_d = DCA_DRAIN_STREAM;
      DCA_DRAIN_STREAM: begin
        if (row_ready) begin
          if (cnt_q == LastIdx) begin
            cnt_d   = '0;
            state_d = DCA_DRAIN_FINISH;
          end else begin
            cnt_d = cnt_q + BW_ROW_INDEX'(1);
          end
        end
      end
      DCA_DRAIN_FINISH: state_d = DCA_DRAIN_IDLE;
      default: state_d = DCA_DRAIN_IDLE;
    endcase
  end

  // row_valid depends on state only; row_ready reaches just shift_up and next state.
  always_comb begin
    busy           = (state_q != DCA_DRAIN_IDLE);
    done           = (state_q == DCA_DRAIN_FINISH);
    mreg_transpose = (state_q == DCA_DRAIN_XPOSE);
    row_valid      = (state_q == DCA_DRAIN_STREAM);
    row_last       = row_valid && (cnt_q == LastIdx);
    row_index      = cnt_q;
    row_data       = mreg_upmost_rdata_list1d;
    mreg_shift_up  = row_valid && row_ready;
  end

endmodule

// File: tb/tb_dca_matrix_row_drainer.sv
// Scoreboard bench: a 4x4 byte matrix-register model feeds the drainer, plus an N=1 build.
module tb_dca_matrix_row_drainer;

  logic        clk = 1'b0;
  logic        rstnn = 1'b0;
  logic        start = 1'b0;
  logic        transpose_first = 1'b0;
  logic        row_ready = 1'b1;
  logic        busy, done, mreg_transpose, mreg_shift_up, row_valid, row_last;
  logic [31:0] mreg_row, row_data;
  logic [1:0]  row_index;

  logic        start1 = 1'b0;
  logic        busy1, done1, xpose1, shift1, valid1, last1;
  logic [7:0]  data1;
  logic [0:0]  index1;
  logic [7:0]  row1_in = 8'hA5;
  logic        tf1 = 1'b0;
  logic        ready1 = 1'b1;

  always #5 clk = ~clk;

  dca_matrix_row_drainer #(.MATRIX_SIZE_PARA(4), .BW_TENSOR_SCALAR(8)) dut (
    .clk(clk), .rstnn(rstnn), .start(start), .transpose_first(transpose_first),
    .busy(busy), .done(done), .mreg_transpose(mreg_transpose), .mreg_shift_up(mreg_shift_up),
    .mreg_upmost_rdata_list1d(mreg_row), .row_valid(row_valid), .row_ready(row_ready),
    .row_data(row_data), .row_index(row_index), .row_last(row_last)
  );

  dca_matrix_row_drainer #(.MATRIX_SIZE_PARA(1), .BW_TENSOR_SCALAR(8)) dut1 (
    .clk(clk), .rstnn(rstnn), .start(start1), .transpose_first(tf1),
    .busy(busy1), .done(done1), .mreg_transpose(xpose1), .mreg_shift_up(shift1),
    .mreg_upmost_rdata_list1d(row1_in), .row_valid(valid1), .row_ready(ready1),
    .row_data(data1), .row_index(index1), .row_last(last1)
  );

  // Matrix register model: row i, element j at bits [8j+:8].
  logic [31:0] mat [4];
  logic [31:0] load_rows [4];
  logic        load_req = 1'b0;
  int          shift_cnt = 0;
  int          xpose_cnt = 0;

  assign mreg_row = mat[0];

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 4; i++) mat[i] <= load_rows[i];
    end else if (mreg_shift_up) begin
      for (int i = 0; i < 3; i++) mat[i] <= mat[i+1];
      mat[3] <= 32'h0;
    end else if (mreg_transpose) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) mat[i][8*j +: 8] <= mat[j][8*i +: 8];
    end
    if (rstnn && mreg_shift_up) shift_cnt <= shift_cnt + 1;
    if (rstnn && mreg_transpose) xpose_cnt <= xpose_cnt + 1;
  end

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  idx;
    logic        last;
  } exp_row_t;

  exp_row_t exp_q [$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_row(input logic [31:0] d, input logic [1:0] i);
    exp_row_t e;
    e.data = d;
    e.idx  = i;
    e.last = (i == 2'd3);
    exp_q.push_back(e);
  endtask

  // Monitor: pops on every handshake, checks hold-while-stalled and control exclusivity.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic [1:0]  prev_idx = '0;

  always @(negedge clk) begin
    exp_row_t e;
    if (rstnn) begin
      chk("xpose_shift_exclusive", {63'd0, mreg_transpose & mreg_shift_up}, 64'd0);
      if (prev_stall && row_valid) begin
        chk("stall_data_hold", {32'd0, row_data}, {32'd0, prev_data});
        chk("stall_index_hold", {62'd0, row_index}, {62'd0, prev_idx});
      end
      if (row_valid && row_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_row", {32'd0, row_data}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("row_data", {32'd0, row_data}, {32'd0, e.data});
          chk("row_index", {62'd0, row_index}, {62'd0, e.idx});
          chk("row_last", {63'd0, row_last}, {63'd0, e.last});
        end
      end
      prev_stall <= row_valid && !row_ready;
      prev_data  <= row_data;
      prev_idx   <= row_index;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  task automatic preload();
    load_rows[0] = 32'h03020100;
    load_rows[1] = 32'h07060504;
    load_rows[2] = 32'h0B0A0908;
    load_rows[3] = 32'h0F0E0D0C;
    @(posedge clk); #1 load_req = 1'b1;
    @(posedge clk); #1 load_req = 1'b0;
  endtask

  // Cycle 0 is the start cycle; bp applies ready pattern 1,0,0,1,0,1,1 repeating.
  task automatic run_drain(input logic tf, input bit bp, input bit inj,
                           output int done_cyc, output int first_v);
    logic [6:0] pat;
    pat      = 7'b1101001;
    done_cyc = -1;
    first_v  = -1;
    for (int c = 0; c < 40 && done_cyc < 0; c++) begin
      @(posedge clk); #1;
      start           = (c == 0) || (inj && (c == 2 || c == 5));
      transpose_first = tf;
      row_ready       = bp ? pat[c % 7] : 1'b1;
      @(negedge clk);
      if (row_valid && first_v < 0) first_v = c;
      if (done) done_cyc = c;
    end
    @(posedge clk); #1;
    start     = 1'b0;
    row_ready = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_row_valid"}, {63'd0, row_valid}, 64'd0);
    chk({tag, "_row_last"}, {63'd0, row_last}, 64'd0);
    chk({tag, "_row_index"}, {62'd0, row_index}, 64'd0);
    chk({tag, "_mreg_transpose"}, {63'd0, mreg_transpose}, 64'd0);
    chk({tag, "_mreg_shift_up"}, {63'd0, mreg_shift_up}, 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, fv, sbase, xbase;

    #12;
    chk_reset_outputs("reset");
    @(negedge clk) rstnn = 1'b1;

    // Plain drain.
    preload();
    push_row(32'h03020100, 2'd0);
    push_row(32'h07060504, 2'd1);
    push_row(32'h0B0A0908, 2'd2);
    push_row(32'h0F0E0D0C, 2'd3);
    sbase = shift_cnt; xbase = xpose_cnt;
    run_drain(1'b0, 1'b0, 1'b0, dc, fv);
    chk("plain_first_valid", 64'(fv), 64'd1);
    chk("plain_done_cycle", 64'(dc), 64'd5);
    chk("plain_shift_count", 64'(shift_cnt - sbase), 64'd4);
    chk("plain_xpose_count", 64'(xpose_cnt - xbase), 64'd0);
    chk("plain_queue_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    chk("plain_busy_after_done", {63'd0, busy}, 64'd0);

    // Transpose first.
    preload();
    push_row(32'h0C080400, 2'd0);
    push_row(32'h0D090501, 2'd1);
    push_row(32'h0E0A0602, 2'd2);
    push_row(32'h0F0B0703, 2'd3);
    sbase = shift_cnt; xbase = xpose_cnt;
    run_drain(1'b1, 1'b0, 1'b0, dc, fv);
    chk("xpose_first_valid", 64'(fv), 64'd2);
    chk("xpose_done_cycle", 64'(dc), 64'd6);
    chk("xpose_pulse_count", 64'(xpose_cnt - xbase), 64'd1);
    chk("xpose_shift_count", 64'(shift_cnt - sbase), 64'd4);
    chk("xpose_queue_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure.
    preload();
    push_row(32'h03020100, 2'd0);
    push_row(32'h07060504, 2'd1);
    push_row(32'h0B0A0908, 2'd2);
    push_row(32'h0F0E0D0C, 2'd3);
    sbase = shift_cnt;
    run_drain(1'b0, 1'b1, 1'b0, dc, fv);
    chk("bp_done_cycle", 64'(dc), 64'd8);
    chk("bp_shift_count", 64'(shift_cnt - sbase), 64'd4);
    chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // start during STREAM and on the done cycle is ignored.
    preload();
    push_row(32'h03020100, 2'd0);
    push_row(32'h07060504, 2'd1);
    push_row(32'h0B0A0908, 2'd2);
    push_row(32'h0F0E0D0C, 2'd3);
    sbase = shift_cnt;
    run_drain(1'b0, 1'b0, 1'b1, dc, fv);
    chk("inj_done_cycle", 64'(dc), 64'd5);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("inj_busy_idle", {63'd0, busy}, 64'd0);
      chk("inj_no_valid", {63'd0, row_valid}, 64'd0);
    end
    chk("inj_shift_count", 64'(shift_cnt - sbase), 64'd4);
    chk("inj_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset after the second handshake, then a fresh drain from index 0.
    preload();
    push_row(32'h03020100, 2'd0);
    push_row(32'h07060504, 2'd1);
    sbase = shift_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rstnn = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    chk("midreset_shift_count", 64'(shift_cnt - sbase), 64'd2);
    chk("midreset_queue_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk) rstnn = 1'b1;
    push_row(32'h0B0A0908, 2'd0);
    push_row(32'h0F0E0D0C, 2'd1);
    push_row(32'h00000000, 2'd2);
    push_row(32'h00000000, 2'd3);
    run_drain(1'b0, 1'b0, 1'b0, dc, fv);
    chk("redrain_done_cycle", 64'(dc), 64'd5);
    chk("redrain_queue_empty", 64'(exp_q.size()), 64'd0);

    // N=1 build.
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    @(negedge clk);
    chk("n1_valid", {63'd0, valid1}, 64'd1);
    chk("n1_last", {63'd0, last1}, 64'd1);
    chk("n1_index", {63'd0, index1}, 64'd0);
    chk("n1_data", {56'd0, data1}, 64'hA5);
    chk("n1_shift", {63'd0, shift1}, 64'd1);
    @(negedge clk);
    chk("n1_done", {63'd0, done1}, 64'd1);
    chk("n1_busy_finish", {63'd0, busy1}, 64'd1);
    @(negedge clk);
    chk("n1_idle", {63'd0, busy1}, 64'd0);
    chk("n1_xpose_never", {63'd0, xpose1}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
